nos_dac_rx: RTL and testbench

- Receiver for the NOS DAC serial interface (bck, data_l, data_r, le) driven by the NOS DAC transmitter.
- Oversamples the four lines on its own system clock and recovers each latched stereo sample as one parallel 64-bit word, in the same packing the transmitter consumes.
- Used as a loopback monitor in the transceiver and as the checker in transmitter regression benches.

---
 rtl/nos_dac_rx.sv | 155 +++++++++++++++
 tb/tb_nos_dac_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nos_dac_rx.sv
// NOS DAC serial receiver: oversamples bck/data_l/data_r/le on clk and
// recovers each latched stereo sample as one MSB-aligned 64-bit word.
module nos_dac_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BITS    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bck_in,
  input  logic        data_l_in,
  input  logic        data_r_in,
  input  logic        le_in,
  input  logic [1:0]  nos_bitnum,
  output logic [63:0] data,
  output logic        valid,
  output logic        frame_err,
  output logic [5:0]  bit_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  // Lane order inside each sync stage: [0]=bck [1]=data_l [2]=data_r [3]=le
  logic [SYNC_STAGES-1:0][3:0] r_sync_p0;
  logic [3:0]                  w_sync;
  logic                        r_prev_bck_p0, r_prev_le_p0;
  logic                        w_bck_rise, w_le_rise;
  logic                        r_bck_rise_p1, r_le_rise_p1, r_bit_l_p1, r_bit_r_p1;
  state_t                      r_state, w_state_nxt;
  logic [5:0]                  r_cnt, w_cnt_nxt;
  logic [1:0]                  r_nos;
  logic [MAX_BITS-1:0]         r_sr_l, r_sr_r;
  logic                        w_shift, w_load_nos, w_latch;
  logic [5:0]                  w_n;
  logic [63:0]                 r_data_p2;
  logic                        r_valid_p2, r_err_p2;
  logic [5:0]                  r_bit_count_p2;

  function automatic logic [5:0] decode_n(input logic [1:0] nos);
    case (nos)
      2'd0:    return 6'd16;
      2'd1:    return 6'd18;
      2'd2:    return 6'd20;
      default: return 6'd24;
    endcase
  endfunction

  // Keep the low n bits of the shift register and left-justify them in 32 bits.
  function automatic logic [31:0] pack_word(input logic [MAX_BITS-1:0] sr, input logic [5:0] n);
    logic [31:0] w;
    w = 32'(sr) & ((32'd1 << n) - 32'd1);
    return w << (6'd32 - n);
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] cnt);
    return (cnt == 6'd63) ? cnt : cnt + 6'd1;
  endfunction

  assign w_sync     = r_sync_p0[SYNC_STAGES-1];
  assign w_bck_rise = w_sync[0] & ~r_prev_bck_p0;
  assign w_le_rise  = w_sync[3] & ~r_prev_le_p0;
  assign w_n        = decode_n(r_nos);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_load_nos  = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_bck_rise_p1) begin
          w_shift     = 1'b1;
          w_load_nos  = 1'b1;
          w_cnt_nxt   = 6'd1;
          w_state_nxt = r_le_rise_p1 ? LATCH : SHIFT;
        end else if (r_le_rise_p1) begin
          w_cnt_nxt   = 6'd0;
          w_state_nxt = LATCH;
        end
      end
      SHIFT: begin
        if (r_bck_rise_p1) begin
          w_shift   = 1'b1;
          w_cnt_nxt = sat_inc(r_cnt);
        end
        if (r_le_rise_p1) w_state_nxt = LATCH;
      end
      LATCH: begin
        w_latch = 1'b1;
        // A bit arriving during the latch cycle opens the next frame.
        if (r_bck_rise_p1) begin
          w_shift     = 1'b1;
          w_load_nos  = 1'b1;
          w_cnt_nxt   = 6'd1;
          w_state_nxt = SHIFT;
        end else begin
          w_cnt_nxt   = 6'd0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0      <= '0;
      r_prev_bck_p0  <= 1'b0;
      r_prev_le_p0   <= 1'b0;
      r_bck_rise_p1  <= 1'b0;
      r_le_rise_p1   <= 1'b0;
      r_bit_l_p1     <= 1'b0;
      r_bit_r_p1     <= 1'b0;
      r_state        <= IDLE;
      r_cnt          <= 6'd0;
      r_nos          <= 2'd0;
      r_sr_l         <= '0;
      r_sr_r         <= '0;
      r_data_p2      <= 64'd0;
      r_valid_p2     <= 1'b0;
      r_err_p2       <= 1'b0;
      r_bit_count_p2 <= 6'd0;
    end else begin
      // p0: synchronizers and previous-value flops
      r_sync_p0     <= {r_sync_p0[SYNC_STAGES-2:0], {le_in, data_r_in, data_l_in, bck_in}};
      r_prev_bck_p0 <= w_sync[0];
      r_prev_le_p0  <= w_sync[3];
      // p1: registered edge strobes with the data bits sampled on bck_rise
      r_bck_rise_p1 <= w_bck_rise;
      r_le_rise_p1  <= w_le_rise;
      r_bit_l_p1    <= w_sync[1];
      r_bit_r_p1    <= w_sync[2];
      // p2: frame state machine, shift registers and output word
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load_nos) r_nos <= nos_bitnum;
      if (w_shift) begin
        r_sr_l <= {r_sr_l[MAX_BITS-2:0], r_bit_l_p1};
        r_sr_r <= {r_sr_r[MAX_BITS-2:0], r_bit_r_p1};
      end
      r_valid_p2 <= w_latch;
      r_err_p2   <= w_latch & (r_cnt < w_n);
      if (w_latch) begin
        r_data_p2      <= {pack_word(r_sr_l, w_n), pack_word(r_sr_r, w_n)};
        r_bit_count_p2 <= r_cnt;
      end
    end
  end

  assign data      = r_data_p2;
  assign valid     = r_valid_p2;
  assign frame_err = r_err_p2;
  assign bit_count = r_bit_count_p2;

endmodule

// File: tb/tb_nos_dac_rx.sv
// Self-checking bench for nos_dac_rx: directed NOS frames plus random frames
// compared against a bit-history reference model.
module tb_nos_dac_rx;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset, bck, dl, dr, le;
  logic [1:0]  nos;
  logic [63:0] data;
  logic        valid, frame_err;
  logic [5:0]  bit_count;

  always #5 clk = ~clk;

  nos_dac_rx #(.SYNC_STAGES(SYNC), .MAX_BITS(24)) dut (
    .clk(clk), .reset(reset), .bck_in(bck), .data_l_in(dl), .data_r_in(dr),
    .le_in(le), .nos_bitnum(nos), .data(data), .valid(valid),
    .frame_err(frame_err), .bit_count(bit_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every valid strobe with its cycle number.
  logic [63:0] q_data[$];
  logic        q_err[$];
  logic [5:0]  q_cnt[$];
  int          q_cyc[$];
  int          dbl = 0, stray = 0;
  logic        prev_v = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      q_data.push_back(data);
      q_err.push_back(frame_err);
      q_cnt.push_back(bit_count);
      q_cyc.push_back(cyc);
    end
    if (valid && prev_v) dbl <= dbl + 1;
    if (frame_err && !valid) stray <= stray + 1;
    prev_v <= valid;
  end

  // Reference model: full per-channel bit history since reset.
  logic [63:0] m_hl, m_hr;
  int          m_cnt, m_n, le_cyc;
  bit          m_started;
  logic [63:0] exp_data, last_data;
  logic        exp_err;
  logic [5:0]  exp_cnt;
  int          checks = 0, errors = 0;

  function automatic int dec(input logic [1:0] v);
    case (v)
      2'd0:    return 16;
      2'd1:    return 18;
      2'd2:    return 20;
      default: return 24;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hl = 64'd0; m_hr = 64'd0; m_cnt = 0; m_n = 16; m_started = 1'b0;
  endtask

  task automatic model_bit(input logic l, input logic r);
    if (!m_started) begin
      m_started = 1'b1;
      m_n = dec(nos);
    end
    m_hl = {m_hl[62:0], l};
    m_hr = {m_hr[62:0], r};
    m_cnt++;
  endtask

  task automatic end_frame_model();
    logic [63:0] mask;
    mask     = (64'd1 << m_n) - 64'd1;
    exp_data = {32'((m_hl & mask) << (32 - m_n)), 32'((m_hr & mask) << (32 - m_n))};
    exp_cnt  = (m_cnt > 63) ? 6'd63 : 6'(m_cnt);
    exp_err  = (m_cnt < m_n);
    m_cnt = 0;
    m_started = 1'b0;
  endtask

  task automatic drive_bit(input logic l, input logic r, input bit with_le);
    @(negedge clk);
    bck = 1'b0; dl = l; dr = r;
    repeat (3) @(negedge clk);
    bck = 1'b1;
    if (with_le) begin
      le = 1'b1;
      le_cyc = cyc;
    end
    model_bit(l, r);
    repeat (3) @(negedge clk);
    le = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] l, input logic [31:0] r, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) drive_bit(l[i], r[i], 1'b0);
  endtask

  task automatic send_rand(input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic pulse_le();
    @(negedge clk);
    bck = 1'b0;
    repeat (3) @(negedge clk);
    le = 1'b1;
    le_cyc = cyc;
    repeat (3) @(negedge clk);
    le = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // le rises, then bck rises one cycle later so the bit lands in the latch cycle.
  task automatic le_then_bit(input logic l, input logic r);
    @(negedge clk);
    bck = 1'b0; dl = l; dr = r;
    repeat (3) @(negedge clk);
    le = 1'b1;
    le_cyc = cyc;
    end_frame_model();
    @(negedge clk);
    bck = 1'b1;
    model_bit(l, r);
    repeat (3) @(negedge clk);
    le = 1'b0;
  endtask

  task automatic verify(input string tag);
    int w;
    logic [63:0] v;
    w = 0;
    while (q_data.size() == 0 && w < 40) begin
      @(negedge clk); #1;
      w++;
    end
    v = (q_data.size() != 0) ? 64'd1 : 64'd0;
    chk({tag, "_valid"}, v, 64'd1);
    if (q_data.size() != 0) begin
      last_data = q_data.pop_front();
      chk({tag, "_data"}, last_data, exp_data);
      chk({tag, "_err"}, 64'(q_err.pop_front()), 64'(exp_err));
      chk({tag, "_cnt"}, 64'(q_cnt.pop_front()), 64'(exp_cnt));
      chk({tag, "_lat"}, 64'(q_cyc.pop_front() - le_cyc), 64'(SYNC + 3));
    end
  endtask

  task automatic frame_end(input string tag);
    pulse_le();
    end_frame_model();
    verify(tag);
  endtask

  initial begin
    reset = 1'b1; bck = 1'b0; dl = 1'b0; dr = 1'b0; le = 1'b0; nos = 2'd0;
    le_cyc = 0; last_data = 64'd0;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_data", data, 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_cnt", 64'(bit_count), 64'd0);

    nos = 2'd0;
    send_word(32'hA5C3, 32'h1234, 16);
    frame_end("nos16");
    chk("nos16_const", last_data, 64'hA5C3_0000_1234_0000);

    nos = 2'd3;
    send_word(32'h800001, 32'h7FFFFF, 24);
    frame_end("nos24");
    chk("nos24_const", last_data, 64'h8000_0100_7FFF_FF00);

    nos = 2'd1;
    send_word(32'h3FFFF, 32'h00001, 18);
    frame_end("nos18");
    chk("nos18_const", last_data, 64'hFFFF_C000_0000_4000);

    nos = 2'd2;
    send_word(32'h5A5, 32'hF0F, 12);
    frame_end("short");
    chk("short_err", 64'(exp_err), 64'd1);
    chk("short_cnt", 64'(exp_cnt), 64'd12);

    nos = 2'd0;
    send_rand(24);
    send_word(32'hBEEF, 32'hBEEF, 16);
    frame_end("cont");
    chk("cont_left", 64'(last_data[63:48]), 64'hBEEF);
    chk("cont_right", 64'(last_data[31:16]), 64'hBEEF);

    send_rand(5);
    nos = 2'd3;
    send_rand(11);
    frame_end("nos_hold");
    send_rand(24);
    frame_end("nos_new");

    nos = 2'd0;
    send_word(32'h0, 32'h0, 15);
    drive_bit(1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    end_frame_model();
    verify("coincide");
    chk("coincide_const", last_data, 64'h0001_0000_0001_0000);

    send_rand(16);
    le_then_bit(1'b1, 1'b0);
    verify("latch_bck");
    send_rand(15);
    frame_end("after_latch");

    send_rand(8);
    @(negedge clk);
    bck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    #1;
    chk("abort_novalid", 64'(q_data.size()), 64'd0);
    chk("abort_data", data, 64'd0);
    nos = 2'd0;
    send_word(32'hFFFF, 32'hFFFF, 16);
    frame_end("post_rst");
    chk("post_rst_const", last_data, 64'hFFFF_0000_FFFF_0000);

    for (int k = 0; k < 6; k++) begin
      nos = 2'($urandom_range(0, 3));
      send_rand(int'($urandom_range(8, 70)));
      frame_end($sformatf("rand%0d", k));
    end

    repeat (5) @(negedge clk);
    chk("one_cycle_valid", 64'(dbl), 64'd0);
    chk("err_only_with_valid", 64'(stray), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
